step_feature_extractor: RTL and testbench
=========================================

STEP_FEATURE_EXTRACTOR -- requirements
Module: step_feature_extractor

Interface
REQ-001 Parameter WINDOW_LOG2, default 3, log2 of samples per window N; legal range 1..6.
REQ-002 Parameter NOISE_FLOOR, default 8, peak-to-peak dead-band threshold; used only under REQ-030.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 sample_in  input  8  unsigned accelerometer magnitude sample.
REQ-006 sample_valid  input  1  sample_in is valid this cycle.
REQ-007 sample_ready  output  1  block accepts sample_in this cycle.
REQ-008 feat_A  output  8  peak-to-peak of last completed window; drives the ExBlock A input.
REQ-009 feat_B  output  8  floor mean of last completed window; drives the ExBlock B input.
REQ-010 feat_valid  output  1  feat_A/feat_B hold an unconsumed feature pair.
REQ-011 feat_ready  input  1  downstream consumes the feature pair this cycle.
REQ-012 win_count  output  8  number of windows produced, modulo 256.

Function
REQ-013 A sample is accepted on any posedge where sample_valid and sample_ready are both 1; no other cycle alters the window state.
REQ-014 An internal sample counter cnt, WINDOW_LOG2 bits wide, increments on each accepted sample and wraps from N-1 to 0.
REQ-015 The first accepted sample (cnt==0) loads min, max and sum with that sample; each later sample updates min=min(min,s), max=max(max,s), sum+=s.
REQ-016 sum is 8+WINDOW_LOG2 bits wide and never overflows.
REQ-017 The window closes on the accepted sample where cnt==N-1. That sample is included in the result.
REQ-018 On the close edge: feat_A = max-min, feat_B = sum>>WINDOW_LOG2 (truncating), feat_valid = 1, win_count += 1 (wraps 255->0).
REQ-019 Latency: feat_valid is 1 in the cycle after the handshake of the Nth sample.
REQ-020 feat_valid clears on a posedge with feat_valid=1 and feat_ready=1, unless a window closes on the same edge; in that case feat_valid stays 1 and the new values load.
REQ-021 feat_A and feat_B change only on the close edge and remain stable while feat_valid=1.
REQ-022 sample_ready = NOT(cnt==N-1 AND feat_valid AND NOT feat_ready). This path is combinational from feat_ready.
REQ-023 Overrun is impossible: the closing sample stalls until the pending pair is consumed. Samples before it keep accumulating during the stall.
REQ-024 feat_ready while feat_valid=0 is ignored.

Reset
REQ-025 On rst, synchronously: cnt=0, sum=0, min=8'hFF, max=0, feat_A=0, feat_B=0, feat_valid=0, win_count=0.
REQ-026 rst asserted mid-window discards the partial window. After release, the next accepted sample starts a fresh window.
REQ-027 rst overrides every simultaneous handshake.
REQ-028 sample_ready is 1 in every cycle with rst=0 and feat_valid=0.
REQ-029 No output is X after the first reset edge.

Configuration
REQ-030 Macro STEP_FEAT_DEADBAND_EN defined: on close, if (max-min) < NOISE_FLOOR then feat_A=0, otherwise max-min. feat_B is unaffected.
REQ-031 Macro STEP_FEAT_DEADBAND_EN undefined: feat_A is always max-min and NOISE_FLOOR is unused.

Verification (WINDOW_LOG2=3, feat_ready=1 unless stated)
REQ-032 Ramp 0..7 on consecutive cycles -> feat_valid one cycle after the 8th sample, feat_A=7, feat_B=3, win_count=1.
REQ-033 Alternating 0,255 x4 -> feat_A=255, feat_B=127. Then 8 samples of 100 -> feat_A=0, feat_B=100, win_count=2.
REQ-034 feat_ready held 0 and 16 samples of 20 offered -> first 15 accepted, sample_ready=0 with the 16th pending, first pair unchanged. Pulse feat_ready -> 16th accepted and second pair appears the next cycle.
REQ-035 5 samples of 200, rst one cycle, then 8 samples of 50 -> feat_A=0, feat_B=50, win_count=1.
REQ-036 Samples 10,11,12,13,14,15,15,15 -> feat_B=13. feat_A=0 with STEP_FEAT_DEADBAND_EN defined, feat_A=5 without it.
REQ-037 Drive 256 windows -> win_count wraps to 0 and feat_valid behaves normally.

Source files
------------

// File: rtl/step_feature_extractor.sv
// Windowed peak-to-peak / mean feature extractor for accelerometer magnitude samples.
// Optional macro STEP_FEAT_DEADBAND_EN zeroes feat_A when the window swing is below NOISE_FLOOR.
module step_feature_extractor #(
  parameter int WINDOW_LOG2 = 3,
  parameter int NOISE_FLOOR = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sample_in,
  input  logic       sample_valid,
  output logic       sample_ready,
  output logic [7:0] feat_A,
  output logic [7:0] feat_B,
  output logic       feat_valid,
  input  logic       feat_ready,
  output logic [7:0] win_count
);

  localparam int SW = 8 + WINDOW_LOG2;
  localparam logic [WINDOW_LOG2-1:0] CNT_LAST = '1;

  logic [WINDOW_LOG2-1:0] cnt;
  logic [SW-1:0]          sum;
  logic [7:0]             min_q;
  logic [7:0]             max_q;

  logic                   last;
  logic                   accept;
  logic                   close;
  logic [7:0]             min_n;
  logic [7:0]             max_n;
  logic [SW-1:0]          sum_n;
  logic [7:0]             diff_n;
  logic [7:0]             feat_a_n;

  assign last = (cnt == CNT_LAST);
  // The closing sample waits until the pending pair is taken, so a result is never overwritten.
  assign sample_ready = !(last && feat_valid && !feat_ready);
  assign accept = sample_valid && sample_ready;
  assign close  = accept && last;

  always_comb begin
    min_n = sample_in;
    max_n = sample_in;
    sum_n = {{WINDOW_LOG2{1'b0}}, sample_in};
    if (cnt != '0) begin
      if (min_q < sample_in) min_n = min_q;
      if (max_q > sample_in) max_n = max_q;
      sum_n = sum + {{WINDOW_LOG2{1'b0}}, sample_in};
    end
    diff_n = max_n - min_n;
  end

`ifdef STEP_FEAT_DEADBAND_EN
  assign feat_a_n = (int'(diff_n) < NOISE_FLOOR) ? 8'd0 : diff_n;
`else
  localparam int unused_noise_floor = NOISE_FLOOR;
  assign feat_a_n = diff_n;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      sum        <= '0;
      min_q      <= 8'hFF;
      max_q      <= 8'h00;
      feat_A     <= 8'h00;
      feat_B     <= 8'h00;
      feat_valid <= 1'b0;
      win_count  <= 8'h00;
    end else begin
      if (accept) begin
        cnt   <= cnt + 1'b1;
        sum   <= sum_n;
        min_q <= min_n;
        max_q <= max_n;
      end
      // A close on the same edge as a consume keeps feat_valid high with the new pair.
      if (close) begin
        feat_A     <= feat_a_n;
        feat_B     <= sum_n[SW-1:WINDOW_LOG2];
        feat_valid <= 1'b1;
        win_count  <= win_count + 8'd1;
      end else if (feat_valid && feat_ready) begin
        feat_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_step_feature_extractor.sv
// Self-checking bench for step_feature_extractor (WINDOW_LOG2=3): vector table plus stall/reset/wrap sequences.
module tb_step_feature_extractor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] sample_in = 8'd0;
  logic       sample_valid = 1'b0;
  logic       sample_ready;
  logic [7:0] feat_A;
  logic [7:0] feat_B;
  logic       feat_valid;
  logic       feat_ready = 1'b1;
  logic [7:0] win_count;

  step_feature_extractor dut (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .feat_A       (feat_A),
    .feat_B       (feat_B),
    .feat_valid   (feat_valid),
    .feat_ready   (feat_ready),
    .win_count    (win_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] wc;
  } exp_t;

  typedef struct {
    logic [7:0] s [8];
    logic [7:0] exp_a;
    logic [7:0] exp_b;
    logic [7:0] exp_wc;
    logic       do_rst;
  } vec_t;

`ifdef STEP_FEAT_DEADBAND_EN
  localparam logic [7:0] TEN_A = 8'd0;
`else
  localparam logic [7:0] TEN_A = 8'd5;
`endif

  int   checks = 0;
  int   errors = 0;
  int   exp_wc = 0;
  exp_t sb [$];
  exp_t e_mon;
  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: a pair is compared when the bench consumes it.
  always @(negedge clk) begin
    if (!rst && !feat_valid) check("ready_idle", {31'd0, sample_ready}, 32'd1);
    if (!rst && feat_valid && feat_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_pair", {31'd0, feat_valid}, 32'd0);
      end else begin
        e_mon = sb.pop_front();
        check("feat_A", {24'd0, feat_A}, {24'd0, e_mon.a});
        check("feat_B", {24'd0, feat_B}, {24'd0, e_mon.b});
        check("win_count", {24'd0, win_count}, {24'd0, e_mon.wc});
      end
    end
  end

  function automatic exp_t model(input logic [7:0] s [8], input logic [7:0] wc);
    int   mn = 255;
    int   mx = 0;
    int   sm = 0;
    exp_t r;
    for (int i = 0; i < 8; i++) begin
      if (int'(s[i]) < mn) mn = int'(s[i]);
      if (int'(s[i]) > mx) mx = int'(s[i]);
      sm += int'(s[i]);
    end
    r.a = 8'(mx - mn);
`ifdef STEP_FEAT_DEADBAND_EN
    if ((mx - mn) < 8) r.a = 8'd0;
`endif
    r.b  = 8'(sm >> 3);
    r.wc = wc;
    return r;
  endfunction

  // All tasks start and end at posedge+#1.
  task automatic send(input logic [7:0] s);
    int n = 0;
    sample_in    = s;
    sample_valid = 1'b1;
    @(negedge clk);
    while (!sample_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!sample_ready) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    exp_wc = 0;
    check("rst_feat_valid", {31'd0, feat_valid}, 32'd0);
    check("rst_feat_A", {24'd0, feat_A}, 32'd0);
    check("rst_feat_B", {24'd0, feat_B}, 32'd0);
    check("rst_win_count", {24'd0, win_count}, 32'd0);
    check("rst_sample_ready", {31'd0, sample_ready}, 32'd1);
  endtask

  task automatic send_window(input logic [7:0] s [8], input exp_t e);
    for (int i = 0; i < 8; i++) begin
      send(s[i]);
      if (i == 6 && feat_ready) check("pre_close_valid", {31'd0, feat_valid}, 32'd0);
    end
    check("latency_valid", {31'd0, feat_valid}, 32'd1);
    sb.push_back(e);
  endtask

  initial begin
    logic [7:0] w [8];
    exp_t       ex;

    vecs[0] = '{s: '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7},
                exp_a: 8'd7, exp_b: 8'd3, exp_wc: 8'd1, do_rst: 1'b1};
    vecs[1] = '{s: '{8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255},
                exp_a: 8'd255, exp_b: 8'd127, exp_wc: 8'd1, do_rst: 1'b1};
    vecs[2] = '{s: '{8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100},
                exp_a: 8'd0, exp_b: 8'd100, exp_wc: 8'd2, do_rst: 1'b0};
    vecs[3] = '{s: '{8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd15, 8'd15},
                exp_a: TEN_A, exp_b: 8'd13, exp_wc: 8'd3, do_rst: 1'b0};
    vecs[4] = '{s: '{8'd3, 8'd250, 8'd17, 8'd90, 8'd128, 8'd64, 8'd1, 8'd200},
                exp_a: 8'd249, exp_b: 8'd94, exp_wc: 8'd4, do_rst: 1'b0};

    for (int v = 0; v < 5; v++) begin
      if (vecs[v].do_rst) do_reset();
      send_window(vecs[v].s, '{a: vecs[v].exp_a, b: vecs[v].exp_b, wc: vecs[v].exp_wc});
    end
    repeat (2) @(posedge clk);
    #1;

    // Downstream stalls: first window of 20 held, next window of 30 accumulates up to its last sample.
    do_reset();
    feat_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(8'd20);
    check("stall_first_valid", {31'd0, feat_valid}, 32'd1);
    sb.push_back('{a: 8'd0, b: 8'd20, wc: 8'd1});
    for (int i = 0; i < 7; i++) send(8'd30);
    sample_in    = 8'd30;
    sample_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_ready", {31'd0, sample_ready}, 32'd0);
      check("stall_hold_A", {24'd0, feat_A}, 32'd0);
      check("stall_hold_B", {24'd0, feat_B}, 32'd20);
      check("stall_hold_valid", {31'd0, feat_valid}, 32'd1);
    end
    @(posedge clk);
    #1;
    feat_ready = 1'b1;
    @(negedge clk);
    check("release_ready", {31'd0, sample_ready}, 32'd1);
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    check("second_pair_valid", {31'd0, feat_valid}, 32'd1);
    check("second_pair_B", {24'd0, feat_B}, 32'd30);
    sb.push_back('{a: 8'd0, b: 8'd30, wc: 8'd2});
    repeat (2) @(posedge clk);
    #1;

    // Mid-window reset with a simultaneous offered sample discards the partial window.
    do_reset();
    for (int i = 0; i < 5; i++) send(8'd200);
    rst          = 1'b1;
    sample_in    = 8'd200;
    sample_valid = 1'b1;
    @(posedge clk);
    #1;
    rst          = 1'b0;
    sample_valid = 1'b0;
    check("midrst_valid", {31'd0, feat_valid}, 32'd0);
    check("midrst_wc", {24'd0, win_count}, 32'd0);
    for (int i = 0; i < 8; i++) w[i] = 8'd50;
    send_window(w, '{a: 8'd0, b: 8'd50, wc: 8'd1});
    repeat (2) @(posedge clk);
    #1;

    // 256 windows: win_count wraps back to zero.
    do_reset();
    for (int k = 0; k < 256; k++) begin
      for (int i = 0; i < 8; i++) w[i] = 8'((k * 7 + i * i * 3 + (k % 5) * i * 11) & 255);
      exp_wc = (exp_wc + 1) & 255;
      ex = model(w, 8'(exp_wc));
      send_window(w, ex);
    end
    repeat (2) @(posedge clk);
    #1;
    check("wrap_wc", {24'd0, win_count}, 32'd0);
    check("wrap_valid", {31'd0, feat_valid}, 32'd0);
    check("sb_empty", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
